// File: rtl/filter_sample_serializer.sv
`timescale 1ns/1ps
// filter_sample_serializer
//   Buffers filtered 8-bit samples in a small FIFO and sends each one as an
//   asynchronous serial frame: start (0), 8 data bits LSB first, optional even
//   parity, stop (1). Consecutive frames are sent with no idle gap.
//
// Ports
//   clk         clock
//   reset       asynchronous reset, active-high
//   s_data      sample to transmit
//   s_valid     s_data is valid
//   s_ready     FIFO can accept a sample (not full)
//   tx          registered serial line, idles high
//   busy        FIFO non-empty or frame in progress
//   fifo_level  number of buffered samples (the sample being shifted is not counted)
//
// Handshake: a sample is transferred on a rising edge where s_valid && s_ready.
// While s_ready is low the source holds s_data/s_valid stable; s_ready depends
// only on the registered count, never on s_valid.
module filter_sample_serializer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    // count alone decides full/empty; pointers simply wrap
    assign s_ready = (count != FULL_CNT);
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // ---------------- Frame FSM ----------------
    state_t            state,    state_n;
    logic [BAUD_W-1:0] baud,     baud_n;
    logic [2:0]        bit_cnt,  bit_n;
    logic [7:0]        shift,    shift_n;
    logic              par_bit,  par_n;
    logic              tx_n;
    logic              load;
    logic              bit_end;
    logic              fifo_ne;

    assign bit_end = (baud == BAUD_LAST);
    // registered count: a sample pushed this edge is seen by the FSM next cycle
    assign fifo_ne = (count != '0);

    always_comb begin
        state_n = state;
        baud_n  = baud;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par_bit;
        tx_n    = tx;
        load    = 1'b0;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (fifo_ne) load = 1'b1;
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    baud_n  = '0;
                    bit_n   = 3'd0;
                    tx_n    = shift[0];
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_n  = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == 3'd7) begin
                        bit_n = 3'd0;
                        if (PARITY_EN != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                        tx_n  = shift[1];
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    baud_n  = '0;
                    tx_n    = 1'b1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    tx_n   = 1'b1;
                    // chain straight into the next start bit when data is waiting
                    if (fifo_ne) load = 1'b1;
                    else         state_n = S_IDLE;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
            end
        endcase

        // pop: load the shifter and start bit from the same edge
        if (load) begin
            pop     = 1'b1;
            state_n = S_START;
            baud_n  = '0;
            bit_n   = 3'd0;
            shift_n = head;
            par_n   = ^head;
            tx_n    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_n;
            shift   <= shift_n;
            par_bit <= par_n;
            tx      <= tx_n;
        end
    end

    assign busy       = (state != S_IDLE) || fifo_ne;
    assign fifo_level = count;

endmodule
